cmd_table_writer: RTL

//  Parametrised command-table manager for the pulse scheduler: stores command words
//  (TIME_START, FREQ, FREQ_STEP, FREQ_RATE, N_impulse, TYPE, Ti, Tp, Tblank1/2) in an
//  N_IDX-row table. It allocates the lowest free row on write, deletes rows by address,
//  and clears the whole table. It also exposes a 1-cycle read port to the downstream

---
 rtl/cmd_table_writer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_table_writer.sv
// -----------------------------------------------------------------------------
// cmd_table_writer
// Command-table manager for the pulse scheduler. Stores CMD_W-bit command words
// in an N_IDX-row table, allocates the lowest free row on write, deletes rows by
// address, clears the whole table, and offers a 1-cycle read port to the
// downstream sequencer. Rows that hold no live command contain the EMPTY word
// (TIME_START field all ones, everything else zero).
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   WR_REQ/WR_DATA    write request and command word (sampled while BUSY=0)
//   WR_ACK/WR_ADDR    1-cycle store acknowledge and the row that was used
//   WR_ERR            1-cycle pulse: write rejected because the table is full
//   DEL_REQ/DEL_ADDR  delete request and row (sampled while BUSY=0)
//   CLR_REQ           clear-all request (sampled while BUSY=0)
//   BUSY              table is not accepting WR/DEL/CLR requests
//   FULL, COUNT       all rows valid / number of valid rows
//   RD_EN/RD_ADDR     read strobe and row, usable at any time
//   RD_DATA/RD_VALID  row contents one cycle later / row holds a live command
// -----------------------------------------------------------------------------
module cmd_table_writer #(
    parameter int N_IDX = 256,
    parameter int AW    = $clog2(N_IDX),
    parameter int CMD_W = 338,
    parameter int TS_W  = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_REQ,
    input  logic [CMD_W-1:0] WR_DATA,
    output logic             WR_ACK,
    output logic [AW-1:0]    WR_ADDR,
    output logic             WR_ERR,
    input  logic             DEL_REQ,
    input  logic [AW-1:0]    DEL_ADDR,
    input  logic             CLR_REQ,
    output logic             BUSY,
    output logic             FULL,
    output logic [AW:0]      COUNT,
    input  logic             RD_EN,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [CMD_W-1:0] RD_DATA,
    output logic             RD_VALID
);

    localparam logic [CMD_W-1:0] EMPTY_WORD = {{TS_W{1'b1}}, {(CMD_W-TS_W){1'b0}}};
    localparam logic [AW-1:0]    LAST_ROW   = AW'(N_IDX - 1);
    localparam logic [AW:0]      COUNT_MAX  = (AW+1)'(N_IDX);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_CLR    = 3'd2,
        S_WR     = 3'd3,
        S_DEL    = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    state_t             state_r;
    logic [AW-1:0]      sweep_ptr_r;
    logic [N_IDX-1:0]   valid_r;
    logic [AW-1:0]      free_idx_r;
    logic [AW-1:0]      free_idx_s;
    logic [AW:0]        count_r;
    logic               full_r;
    logic               busy_r;
    logic               wr_ack_r;
    logic               wr_err_r;
    logic [AW-1:0]      wr_addr_r;
    logic [CMD_W-1:0]   wr_data_r;
    logic [AW-1:0]      del_addr_r;

    logic [CMD_W-1:0]   mem_r [N_IDX];
    logic               mem_we_raw_s;
    logic               mem_we_s;
    logic [AW-1:0]      mem_waddr_s;
    logic [CMD_W-1:0]   mem_wdata_s;

    logic [CMD_W-1:0]   rd_raw_r;
    logic               rd_live_r;
    logic               rd_valid_r;

    // Lowest-index row whose valid bit is clear; returns 0 when every row is valid
    // (FULL blocks writes in that case, so the value is never used).
    function automatic logic [AW-1:0] lowest_free(input logic [N_IDX-1:0] v);
        logic [AW-1:0] idx;
        idx = {AW{1'b0}};
        for (int i = N_IDX - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    assign free_idx_s = lowest_free(valid_r);

    // Control FSM: request arbitration, bitmap/count bookkeeping, registered status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= S_INIT;
            sweep_ptr_r <= {AW{1'b0}};
            valid_r     <= {N_IDX{1'b0}};
            free_idx_r  <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            full_r      <= 1'b0;
            busy_r      <= 1'b1;
            wr_ack_r    <= 1'b0;
            wr_err_r    <= 1'b0;
            wr_addr_r   <= {AW{1'b0}};
            wr_data_r   <= {CMD_W{1'b0}};
            del_addr_r  <= {AW{1'b0}};
        end else begin
            wr_ack_r <= 1'b0;
            wr_err_r <= 1'b0;
            case (state_r)
                S_INIT, S_CLR: begin
                    valid_r <= {N_IDX{1'b0}};
                    count_r <= {(AW+1){1'b0}};
                    if (sweep_ptr_r == LAST_ROW) begin
                        sweep_ptr_r <= {AW{1'b0}};
                        state_r     <= S_SETTLE;
                    end else begin
                        sweep_ptr_r <= sweep_ptr_r + 1'b1;
                    end
                end
                S_IDLE: begin
                    // Priority CLR > DEL > WR; losing requests are dropped.
                    if (CLR_REQ) begin
                        state_r     <= S_CLR;
                        busy_r      <= 1'b1;
                        sweep_ptr_r <= {AW{1'b0}};
                        valid_r     <= {N_IDX{1'b0}};
                        count_r     <= {(AW+1){1'b0}};
                    end else if (DEL_REQ) begin
                        state_r    <= S_DEL;
                        busy_r     <= 1'b1;
                        del_addr_r <= DEL_ADDR;
                    end else if (WR_REQ) begin
                        if (!full_r) begin
                            state_r   <= S_WR;
                            busy_r    <= 1'b1;
                            wr_ack_r  <= 1'b1;
                            wr_addr_r <= free_idx_r;
                            wr_data_r <= WR_DATA;
                        end else begin
                            wr_err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WR: begin
                    valid_r[wr_addr_r] <= 1'b1;
                    count_r            <= count_r + 1'b1;
                    state_r            <= S_SETTLE;
                end
                S_DEL: begin
                    // Deleting an already-free row is legal and leaves COUNT alone.
                    if (valid_r[del_addr_r]) begin
                        valid_r[del_addr_r] <= 1'b0;
                        count_r             <= count_r - 1'b1;
                    end else begin
                        count_r <= count_r;
                    end
                    state_r <= S_SETTLE;
                end
                S_SETTLE: begin
                    free_idx_r <= free_idx_s;
                    full_r     <= (count_r == COUNT_MAX);
                    busy_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    state_r     <= S_INIT;
                    sweep_ptr_r <= {AW{1'b0}};
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    // Table write port selection: sweep, store or delete depending on FSM state.
    always_comb begin
        mem_we_raw_s = 1'b0;
        mem_waddr_s  = sweep_ptr_r;
        mem_wdata_s  = EMPTY_WORD;
        case (state_r)
            S_INIT, S_CLR: begin
                mem_we_raw_s = 1'b1;
            end
            S_WR: begin
                mem_we_raw_s = 1'b1;
                mem_waddr_s  = wr_addr_r;
                mem_wdata_s  = wr_data_r;
            end
            S_DEL: begin
                mem_we_raw_s = 1'b1;
                mem_waddr_s  = del_addr_r;
            end
            default: begin
                mem_we_raw_s = 1'b0;
            end
        endcase
    end

    // Nothing is written while reset is held, so an aborted store never lands.
    assign mem_we_s = mem_we_raw_s & ~RST;

    // Table RAM write port (no reset so it maps onto block RAM).
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Table RAM read port; a same-row write in this cycle is not yet visible.
    always_ff @(posedge CLK) begin
        if (RD_EN) begin
            rd_raw_r <= mem_r[RD_ADDR];
        end
    end

    // Read status: row liveness and an output qualifier that forces RD_DATA to
    // zero from reset until the first read has loaded the RAM output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_valid_r <= 1'b0;
            rd_live_r  <= 1'b0;
        end else begin
            rd_valid_r <= RD_EN & valid_r[RD_ADDR];
            if (RD_EN) begin
                rd_live_r <= 1'b1;
            end
        end
    end

    assign RD_DATA  = rd_live_r ? rd_raw_r : {CMD_W{1'b0}};
    assign RD_VALID = rd_valid_r;
    assign WR_ACK   = wr_ack_r;
    assign WR_ADDR  = wr_addr_r;
    assign WR_ERR   = wr_err_r;
    assign BUSY     = busy_r;
    assign FULL     = full_r;
    assign COUNT    = count_r;

endmodule
